uart_rx_fifo: RTL and testbench

Receive front end for the PicoBlaze system. It takes the asynchronous serial line, recovers 8N1 frames with 16x oversampling, and stores each byte in a small first-word-fall-through FIFO. The PicoBlaze input mux reads the FIFO head directly through r_data. The rd_uart strobe pops the head, rx_empty becomes the rx_not_empty status bit, and error flags report line faults.

---
 rtl/uart_rx_fifo.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 receiver with 16x oversampling feeding a FWFT FIFO.
// Ports: clk, reset (async low), rx, rd_uart, clr_err -> r_data, rx_empty, rx_full, frame_err, overrun.
module uart_rx_fifo #(
  parameter int DVSR    = 163,
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int FIFO_W  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd_uart,
  input  logic       clr_err,
  output logic [7:0] r_data,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW    = $clog2(DVSR);
  localparam int DEPTH = 2**FIFO_W;

  localparam logic [CW-1:0] C_LAST = CW'(DVSR - 1);
  localparam logic [2:0]    N_LAST = 3'(DBIT - 1);
  localparam logic [3:0]    S_LAST = 4'(SB_TICK - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic          sync1;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic          tick;
  state_t        state;
  logic [3:0]    s;
  logic [2:0]    n;
  logic [7:0]    b;
  logic          push;
  logic          fe_set;
  logic          ov_set;
  logic          do_push;
  logic          do_pop;

  logic [FIFO_W:0] wptr;
  logic [FIFO_W:0] rptr;
  logic [7:0]      mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  assign tick = (cnt == C_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
      push  <= 1'b0;
    end else begin
      push <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (s == 4'd7) begin
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s == 4'd15) begin
              b <= {rx_s, b[7:1]};
              s <= '0;
              if (n == N_LAST) state <= STOP;
              else             n     <= n + 3'd1;
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (s == S_LAST) begin
              state <= IDLE;
              push  <= rx_s;
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Framing error is flagged on the same edge the stop sample is taken.
  assign fe_set = (state == STOP) && tick && (s == S_LAST) && !rx_s;

  assign rx_empty = (wptr == rptr);
  assign rx_full  = (wptr[FIFO_W] != rptr[FIFO_W]) &&
                    (wptr[FIFO_W-1:0] == rptr[FIFO_W-1:0]);

  // A pop in the push cycle frees a slot, so a full FIFO still accepts.
  assign do_pop  = rd_uart && !rx_empty;
  assign do_push = push && (!rx_full || do_pop);
  assign ov_set  = push && rx_full && !do_pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[FIFO_W-1:0]] <= b;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  assign r_data = rx_empty ? 8'h00 : mem[rptr[FIFO_W-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (fe_set)       frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (ov_set)       overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and random 8N1 frames against a queue model.
// Ports: none; drives uart_rx_fifo with DVSR=4 (64 clk per bit).
module tb_uart_rx_fifo;

  localparam int DVSR  = 4;
  localparam int BITC  = 16 * DVSR;
  localparam int DEPTH = 16;
  localparam int T_END = 8 + 16 * 8 + 16;

  logic       clk;
  logic       reset;
  logic       rx;
  logic       rd_uart;
  logic       clr_err;
  logic [7:0] r_data;
  logic       rx_empty;
  logic       rx_full;
  logic       frame_err;
  logic       overrun;

  int checks;
  int errors;
  int nprint;
  bit cmp_on;

  uart_rx_fifo #(
    .DVSR(DVSR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rd_uart  (rd_uart),
    .clr_err  (clr_err),
    .r_data   (r_data),
    .rx_empty (rx_empty),
    .rx_full  (rx_full),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: rx is seen two edges late; ticks fall on every DVSR-th edge
  // after reset release; a frame is timed in ticks from its start.
  int         cyc;
  bit         h1, h2;
  bit         busy;
  int         tk;
  logic [7:0] shreg;
  bit         pend;
  logic [7:0] pend_d;
  logic [7:0] q[$];
  bit         m_ferr;
  bit         m_ovr;

  always @(posedge clk or negedge reset) begin
    bit rxs;
    bit fe_set;
    bit ov_set;
    bit pop;
    if (!reset) begin
      cyc = 0; h1 = 1; h2 = 1; busy = 0; tk = 0;
      shreg = 8'h00; pend = 0; pend_d = 8'h00;
      q.delete(); m_ferr = 0; m_ovr = 0;
    end else begin
      rxs = h2; h2 = h1; h1 = rx;
      cyc++;
      fe_set = 0; ov_set = 0;
      pop = rd_uart && (q.size() > 0);
      if (pop) void'(q.pop_front());
      if (pend) begin
        if (q.size() < DEPTH) q.push_back(pend_d);
        else ov_set = 1;
      end
      pend = 0;
      if (!busy) begin
        if (!rxs) begin busy = 1; tk = 0; end
      end else if (cyc % DVSR == 0) begin
        tk++;
        if (tk == 8) begin
          if (rxs) busy = 0;
        end else if (tk > 8 && tk <= 8 + 128 && (tk - 8) % 16 == 0) begin
          shreg = {rxs, shreg[7:1]};
        end else if (tk == T_END) begin
          busy = 0;
          if (rxs) begin pend = 1; pend_d = shreg; end
          else fe_set = 1;
        end
      end
      if (fe_set) m_ferr = 1;
      else if (clr_err) m_ferr = 0;
      if (ov_set) m_ovr = 1;
      else if (clr_err) m_ovr = 0;
    end
  end

  always begin
    logic [7:0] ed;
    bit ee, ef;
    @(negedge clk);
    #1;
    if (cmp_on) begin
      ee = (q.size() == 0);
      ef = (q.size() == DEPTH);
      ed = ee ? 8'h00 : q[0];
      checks++;
      if (rx_empty !== ee || rx_full !== ef || r_data !== ed ||
          frame_err !== m_ferr || overrun !== m_ovr) begin
        errors++;
        if (nprint < 20) begin
          nprint++;
          $display("FAIL model t=%0t got e%b f%b d%02h fe%b ov%b want e%b f%b d%02h fe%b ov%b",
                   $time, rx_empty, rx_full, r_data, frame_err, overrun,
                   ee, ef, ed, m_ferr, m_ovr);
        end
      end
    end
  end

  task automatic lit(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %02h want %02h", nm, got, exp);
    end
  endtask

  task automatic bit_time(input logic v, input int len);
    rx = v;
    repeat (len) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input bit good);
    bit_time(1'b0, BITC);
    for (int i = 0; i < 8; i++) bit_time(d[i], BITC);
    if (good) begin
      bit_time(1'b1, BITC);
    end else begin
      bit_time(1'b0, 48);
      bit_time(1'b1, 16);
    end
  endtask

  task automatic pop(input logic [7:0] exp, input string nm);
    @(negedge clk);
    lit(nm, r_data, exp);
    rd_uart = 1'b1;
    @(negedge clk);
    rd_uart = 1'b0;
  endtask

  task automatic clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    bit got;
    bit done;
    checks = 0; errors = 0; nprint = 0; cmp_on = 1;
    reset = 1'b0; rx = 1'b1; rd_uart = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    lit("rst_empty", rx_empty, 1);
    lit("rst_full", rx_full, 0);
    lit("rst_data", r_data, 8'h00);
    lit("rst_flags", {frame_err, overrun}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    send(8'h5A, 1);
    lit("b5a_empty", rx_empty, 0);
    lit("b5a_data", r_data, 8'h5A);
    lit("b5a_flags", {frame_err, overrun}, 0);
    pop(8'h5A, "b5a_pop");
    #1;
    lit("b5a_after", rx_empty, 1);

    bit_time(1'b0, 20);
    bit_time(1'b1, 200);
    lit("glitch_empty", rx_empty, 1);
    lit("glitch_flags", {frame_err, overrun}, 0);

    send(8'h3C, 0);
    bit_time(1'b1, 100);
    lit("fe_set", frame_err, 1);
    lit("fe_empty", rx_empty, 1);
    clr();
    #1;
    lit("fe_clr", frame_err, 0);

    for (int i = 0; i < 16; i++) send(8'(i), 1);
    lit("fill_full", rx_full, 1);
    lit("fill_ovr0", overrun, 0);
    send(8'h10, 1);
    lit("ovr_set", overrun, 1);
    for (int i = 0; i < 16; i++) pop(8'(i), "fill_pop");
    #1;
    lit("drain_empty", rx_empty, 1);
    clr();
    #1;
    lit("ovr_clr", overrun, 0);

    for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 1);
    lit("full2", rx_full, 1);
    got = 0;
    fork
      send(8'h30, 1);
      begin
        for (int k = 0; k < 2000; k++) begin
          @(negedge clk);
          if (pend) begin got = 1; break; end
        end
        if (got) begin
          lit("push_pop_head", r_data, 8'h20);
          rd_uart = 1'b1;
          @(negedge clk);
          rd_uart = 1'b0;
          #1;
          lit("push_pop_full", rx_full, 1);
          lit("push_pop_ovr", overrun, 0);
        end else begin
          lit("push_wait", 0, 1);
        end
      end
    join
    for (int i = 1; i < 17; i++) pop(8'h20 + 8'(i), "order_pop");
    #1;
    lit("order_empty", rx_empty, 1);

    send(8'h44, 1);
    send(8'h55, 1);
    send(8'h66, 0);
    bit_time(1'b1, 100);
    lit("pre_rst_fe", frame_err, 1);
    bit_time(1'b0, BITC);
    bit_time(1'b1, BITC);
    bit_time(1'b0, BITC);
    bit_time(1'b1, BITC);
    bit_time(1'b0, 30);
    reset = 1'b0;
    rx = 1'b1;
    #1;
    lit("mid_rst_empty", rx_empty, 1);
    lit("mid_rst_flags", {frame_err, overrun}, 0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    bit_time(1'b1, 100);
    lit("after_rst_empty", rx_empty, 1);
    send(8'h81, 1);
    lit("b81_data", r_data, 8'h81);
    pop(8'h81, "b81_pop");

    done = 0;
    fork
      begin
        for (int f = 0; f < 30; f++) begin
          send(8'($urandom), $urandom_range(0, 9) != 0);
          bit_time(1'b1, $urandom_range(20, 80));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          rd_uart = ($urandom_range(0, 999) == 0);
          clr_err = ($urandom_range(0, 399) == 0);
        end
        rd_uart = 1'b0;
        clr_err = 1'b0;
      end
    join
    for (int k = 0; k < 40 && !rx_empty; k++) begin
      @(negedge clk);
      rd_uart = 1'b1;
      @(negedge clk);
      rd_uart = 1'b0;
    end
    repeat (4) @(negedge clk);
    #1;
    lit("final_empty", rx_empty, 1);
    cmp_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
